// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - M stage: load/store bus access, alignment, stall and fault reporting
//
// Purpose: takes the E/M register contents, issues one data-bus transaction per aligned
// load/store, aligns and extends load data, and stalls the pipe while the transaction is open.
// Ports:
//   clk_i, rst_n                 clock, asynchronous active-low reset
//   ED_*_i                       E/M register fields (ops, address/ALU result, store data, rd)
//   data_req_o/we/addr/be/wdata  bus request side; data_gnt_i accepts it
//   data_rvalid_i/rdata/err      bus response side
//   M_stall_o                    freeze upstream stages and the E/M register
//   M_result_o/need_dstE/dstE    write-back / forwarding value
//   M_fault_o                    one-cycle fault pulse (misalign, bus error, timeout)
module memory_access_stage #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic            clk_i,
   input  logic            rst_n,
   input  logic [2:0]      ED_load_op_i,
   input  logic [1:0]      ED_store_op_i,
   input  logic [XLEN-1:0] ED_valE_i,
   input  logic [XLEN-1:0] ED_rs2_data_i,
   input  logic            ED_need_dstE_i,
   input  logic [4:0]      ED_dstE_i,
   input  logic            ED_commit_i,
   output logic            data_req_o,
   output logic            data_we_o,
   output logic [XLEN-1:0] data_addr_o,
   output logic [3:0]      data_be_o,
   output logic [XLEN-1:0] data_wdata_o,
   input  logic            data_gnt_i,
   input  logic            data_rvalid_i,
   input  logic [XLEN-1:0] data_rdata_i,
   input  logic            data_err_i,
   output logic            M_stall_o,
   output logic [XLEN-1:0] M_result_o,
   output logic            M_need_dstE_o,
   output logic [4:0]      M_dstE_o,
   output logic            M_fault_o
);

   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // REQ is not a separate state: it is IDLE while an aligned access is presented.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_wait_cnt;
   logic [XLEN-1:0]   r_rdata;
   logic              r_err;
   logic              r_timeout;

   logic              w_is_load;
   logic              w_is_store;
   logic              w_mem_op;
   logic [1:0]        w_size;
   logic              w_misalign;
   logic              w_access;
   logic              w_stall;
   logic [7:0]        w_cnt_inc;
   logic              w_timeout_hit;
   logic              w_resp_fault;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_load_data;

   // Load wins if the decoder ever sets both op fields.
   assign w_is_load  = ED_commit_i & (ED_load_op_i >= 3'd1) & (ED_load_op_i <= 3'd5);
   assign w_is_store = ED_commit_i & ~w_is_load & (ED_store_op_i != 2'd0);
   assign w_mem_op   = w_is_load | w_is_store;

   always_comb begin
      w_size = SZ_W;
      if (w_is_load) begin
         case (ED_load_op_i)
            3'd1, 3'd4: w_size = SZ_B;
            3'd2, 3'd5: w_size = SZ_H;
            default:    w_size = SZ_W;
         endcase
      end else begin
         case (ED_store_op_i)
            2'd1:    w_size = SZ_B;
            2'd2:    w_size = SZ_H;
            default: w_size = SZ_W;
         endcase
      end
   end

   assign w_misalign = w_mem_op & (((w_size == SZ_H) & ED_valE_i[0]) |
                                   ((w_size == SZ_W) & (ED_valE_i[1:0] != 2'b00)));
   assign w_access   = w_mem_op & ~w_misalign;

   assign w_stall       = ((r_state == S_IDLE) & w_access) | (r_state == S_WAIT);
   assign w_cnt_inc     = r_wait_cnt + 8'd1;
   assign w_timeout_hit = (w_cnt_inc >= LP_MAX_WAIT);
   assign w_resp_fault  = r_err | r_timeout;

   // State register
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; a real response beats a timeout hitting in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               if (w_timeout_hit)   w_state_nxt = S_RESP;
               else if (data_gnt_i) w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (data_rvalid_i || w_timeout_hit) w_state_nxt = S_RESP;
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Wait counter and captured response
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= 8'd0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (r_state == S_RESP || w_state_nxt == S_RESP) r_wait_cnt <= 8'd0;
         else if (w_stall)                              r_wait_cnt <= w_cnt_inc;

         if (r_state == S_WAIT && data_rvalid_i) begin
            r_rdata   <= data_rdata_i;
            r_err     <= data_err_i;
            r_timeout <= 1'b0;
         end else if (w_stall && w_timeout_hit) begin
            r_err     <= 1'b0;
            r_timeout <= 1'b1;
         end
      end
   end

   // Load alignment from the captured word
   always_comb begin
      case (ED_valE_i[1:0])
         2'd0:    w_byte = r_rdata[7:0];
         2'd1:    w_byte = r_rdata[15:8];
         2'd2:    w_byte = r_rdata[23:16];
         default: w_byte = r_rdata[31:24];
      endcase
      w_half = ED_valE_i[1] ? r_rdata[31:16] : r_rdata[15:0];
      case (ED_load_op_i)
         3'd1:    w_load_data = {{24{w_byte[7]}}, w_byte};
         3'd4:    w_load_data = {24'd0, w_byte};
         3'd2:    w_load_data = {{16{w_half[15]}}, w_half};
         3'd5:    w_load_data = {16'd0, w_half};
         default: w_load_data = r_rdata;
      endcase
   end

   // Outputs; control outputs are forced quiet while reset is held.
   always_comb begin
      data_req_o   = rst_n & (r_state == S_IDLE) & w_access;
      data_we_o    = w_is_store;
      data_addr_o  = {ED_valE_i[XLEN-1:2], 2'b00};
      case (w_size)
         SZ_B:    data_be_o = 4'b0001 << ED_valE_i[1:0];
         SZ_H:    data_be_o = ED_valE_i[1] ? 4'b1100 : 4'b0011;
         default: data_be_o = 4'b1111;
      endcase
      case (ED_store_op_i)
         2'd1:    data_wdata_o = {4{ED_rs2_data_i[7:0]}};
         2'd2:    data_wdata_o = {2{ED_rs2_data_i[15:0]}};
         default: data_wdata_o = ED_rs2_data_i;
      endcase
      M_stall_o = rst_n & w_stall;
      M_fault_o = rst_n & (((r_state == S_IDLE) & w_misalign) |
                           ((r_state == S_RESP) & w_resp_fault));
      M_dstE_o  = ED_dstE_i;

      M_result_o    = ED_valE_i;
      M_need_dstE_o = ED_need_dstE_i;
      if (w_is_store) begin
         M_need_dstE_o = 1'b0;
      end else if (w_is_load) begin
         if (r_state == S_RESP) begin
            M_result_o    = w_load_data;
            M_need_dstE_o = ED_need_dstE_i & ~w_resp_fault;
         end else begin
            M_need_dstE_o = 1'b0;
         end
      end
   end

endmodule
